// File: rtl/gpr_check_seq.sv
// Run-and-check sequencer: resets the CPU, runs it until halt/limit/watchdog,
// then scans the GPR file against an expected ROM. Watchdog: GPRCHK_WATCHDOG_EN.
module gpr_check_seq #(
    parameter int DATA_W       = 32,
    parameter int NREGS        = 32,
    parameter int AW           = 5,
    parameter int MAX_STEPS    = 100,
    parameter int STEP_TIMEOUT = 10,
    parameter int RST_CYCLES   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             retire,
    input  logic                             halt,
    output logic                             cpu_hold,
    output logic [AW-1:0]                    reg_raddr,
    input  logic [DATA_W-1:0]                reg_rdata,
    output logic [AW-1:0]                    exp_addr,
    input  logic [DATA_W-1:0]                exp_data,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic                             timeout,
    output logic [$clog2(MAX_STEPS+1)-1:0]   steps,
    output logic [$clog2(NREGS+1)-1:0]       mismatch_cnt,
    output logic [AW-1:0]                    first_bad
);

    localparam int SW = $clog2(MAX_STEPS+1);
    localparam int MW = $clog2(NREGS+1);
    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int CW = AW + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HOLD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_SCAN = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    if (NREGS > (1 << AW)) begin : g_bad_nregs
        $error("NREGS does not fit in AW address bits");
    end
    if (RST_CYCLES < 1 || STEP_TIMEOUT < 1) begin : g_bad_cycles
        $error("RST_CYCLES and STEP_TIMEOUT must be at least 1");
    end

    logic [2:0]    state;
    logic [HW-1:0] hold_cnt;
    logic [CW-1:0] scan_cnt;
    logic          to_q;
    logic          wd_fire;
    logic          launch;
    logic          at_max;
    logic          run_exit;
    logic          cmp_valid;
    logic          miss;
    logic [SW-1:0] steps_inc;
    logic [MW-1:0] mm_nxt;
    logic [AW-1:0] cmp_idx;

    assign exp_addr = reg_raddr;
    assign timeout  = to_q;

    always_comb begin
        launch    = (state == S_IDLE || state == S_DONE) && start;
        steps_inc = steps + SW'(1);
        at_max    = retire && (steps_inc == SW'(MAX_STEPS));
        run_exit  = halt || at_max || wd_fire;
        cmp_valid = (state == S_SCAN) && (scan_cnt != '0);
        miss      = cmp_valid && (reg_rdata != exp_data);
        mm_nxt    = mismatch_cnt + {{(MW-1){1'b0}}, miss};
        cmp_idx   = AW'(scan_cnt - CW'(1));
    end

`ifdef GPRCHK_WATCHDOG_EN
    localparam int TW = $clog2(STEP_TIMEOUT+1);

    logic [TW-1:0] wd_cnt;

    assign wd_fire = (state == S_RUN) && !retire &&
                     (wd_cnt == TW'(STEP_TIMEOUT-1));

    // Counts consecutive RUN cycles without a retire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
            to_q   <= 1'b0;
        end else begin
            if (launch)
                to_q <= 1'b0;
            if (state != S_RUN || retire)
                wd_cnt <= '0;
            else if (wd_fire)
                to_q <= 1'b1;
            else
                wd_cnt <= wd_cnt + TW'(1);
        end
    end
`else
    assign wd_fire = 1'b0;
    assign to_q    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            hold_cnt     <= '0;
            scan_cnt     <= '0;
            cpu_hold     <= 1'b1;
            reg_raddr    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            steps        <= '0;
            mismatch_cnt <= '0;
            first_bad    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state        <= S_HOLD;
                        hold_cnt     <= '0;
                        cpu_hold     <= 1'b1;
                        reg_raddr    <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        steps        <= '0;
                        mismatch_cnt <= '0;
                        first_bad    <= '0;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HW'(RST_CYCLES-1)) begin
                        state    <= S_RUN;
                        cpu_hold <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                S_RUN: begin
                    if (retire)
                        steps <= steps_inc;
                    if (run_exit) begin
                        state     <= S_SCAN;
                        cpu_hold  <= 1'b1;
                        reg_raddr <= '0;
                        scan_cnt  <= '0;
                    end
                end
                S_SCAN: begin
                    // Address k is issued at scan_cnt k, compared at k+1.
                    scan_cnt <= scan_cnt + CW'(1);
                    if (scan_cnt < CW'(NREGS-1))
                        reg_raddr <= reg_raddr + AW'(1);
                    if (miss) begin
                        mismatch_cnt <= mm_nxt;
                        if (mismatch_cnt == '0)
                            first_bad <= cmp_idx;
                    end
                    if (scan_cnt == CW'(NREGS)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (mm_nxt == '0) && !to_q;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    cpu_hold <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpr_check_seq.sv
// Self-checking bench for gpr_check_seq: random CPU retire schedules and
// register contents checked against a per-cycle behavioural model.
module tb_gpr_check_seq;

    localparam int DATA_W       = 32;
    localparam int NREGS        = 32;
    localparam int AW           = 5;
    localparam int MAX_STEPS    = 100;
    localparam int STEP_TIMEOUT = 10;
    localparam int RST_CYCLES   = 2;
    localparam int SW           = $clog2(MAX_STEPS+1);
    localparam int MW           = $clog2(NREGS+1);
    localparam int LEN          = 1024;

`ifdef GPRCHK_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              retire;
    logic              halt;
    logic              cpu_hold;
    logic [AW-1:0]     reg_raddr;
    logic [DATA_W-1:0] reg_rdata;
    logic [AW-1:0]     exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [SW-1:0]     steps;
    logic [MW-1:0]     mismatch_cnt;
    logic [AW-1:0]     first_bad;

    gpr_check_seq #(
        .DATA_W(DATA_W), .NREGS(NREGS), .AW(AW), .MAX_STEPS(MAX_STEPS),
        .STEP_TIMEOUT(STEP_TIMEOUT), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .retire(retire), .halt(halt),
        .cpu_hold(cpu_hold), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
        .exp_addr(exp_addr), .exp_data(exp_data), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .steps(steps),
        .mismatch_cnt(mismatch_cnt), .first_bad(first_bad)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] gpr [NREGS];
    logic [DATA_W-1:0] rom [NREGS];
    bit                ret_s  [LEN];
    bit                halt_s [LEN];

    // Synchronous read ports of the GPR debug port and the expected ROM.
    always @(posedge clk) begin
        reg_rdata <= gpr[reg_raddr];
        exp_data  <= rom[exp_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_equal();
        for (int i = 0; i < NREGS; i++) begin
            rom[i] = $urandom;
            gpr[i] = rom[i];
        end
    endtask

    // Retire schedule: n_ret retires with gaps in [gmin,gmax]; halt lands
    // hdelay cycles after the last retire (negative = never).
    task automatic build(input int n_ret, input int gmin, input int gmax,
                         input int hdelay);
        int c;
        for (int i = 0; i < LEN; i++) begin
            ret_s[i]  = 1'b0;
            halt_s[i] = 1'b0;
        end
        c = 0;
        for (int i = 0; i < n_ret; i++) begin
            c += $urandom_range(gmax, gmin) - 1;
            if (c < LEN) ret_s[c] = 1'b1;
            c++;
        end
        if (hdelay >= 0 && c - 1 + hdelay < LEN)
            halt_s[c-1+hdelay] = 1'b1;
    endtask

    task automatic predict(output int e_steps, output bit e_to,
                           output int e_run);
        int idle;
        e_steps = 0;
        e_to    = 1'b0;
        e_run   = -1;
        idle    = 0;
        for (int c = 0; c < LEN; c++) begin
            if (ret_s[c]) begin
                e_steps++;
                idle = 0;
            end else begin
                idle++;
            end
            if (WD && idle == STEP_TIMEOUT) e_to = 1'b1;
            if (halt_s[c] || e_steps == MAX_STEPS || e_to) begin
                e_run = c + 1;
                return;
            end
        end
    endtask

    task automatic run(input bit start_in_scan);
        int  e_steps, e_run, e_mm, e_fb;
        bit  e_to, e_pass, addr_ok;
        int  holdc, runc, scanc, c;
        predict(e_steps, e_to, e_run);
        e_mm = 0;
        e_fb = 0;
        for (int i = 0; i < NREGS; i++)
            if (gpr[i] != rom[i]) begin
                if (e_mm == 0) e_fb = i;
                e_mm++;
            end
        e_pass = (e_mm == 0) && !e_to;

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        holdc = 0; runc = 0; scanc = 0; c = 0; addr_ok = 1'b1;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            start = 1'b0;
            if (!cpu_hold) begin
                retire = (c < LEN) ? ret_s[c] : 1'b0;
                halt   = (c < LEN) ? halt_s[c] : 1'b0;
                c++;
                runc++;
            end else begin
                retire = 1'b0;
                halt   = 1'b0;
                if (busy && c == 0) holdc++;
                else if (busy) begin
                    if (scanc < NREGS && reg_raddr != AW'(scanc)) addr_ok = 0;
                    if (reg_raddr != exp_addr) addr_ok = 0;
                    if (start_in_scan && scanc == 5) start = 1'b1;
                    scanc++;
                end
            end
            @(negedge clk);
        end
        retire = 1'b0;
        halt   = 1'b0;
        start  = 1'b0;
        chk("done",       done,         1);
        chk("busy_done",  busy,         0);
        chk("hold_done",  cpu_hold,     1);
        chk("steps",      steps,        e_steps);
        chk("timeout",    timeout,      e_to);
        chk("mismatches", mismatch_cnt, e_mm);
        chk("first_bad",  first_bad,    e_fb);
        chk("pass",       pass,         e_pass);
        chk("hold_len",   holdc,        RST_CYCLES);
        chk("run_len",    runc,         e_run);
        chk("scan_len",   scanc,        NREGS + 1);
        chk("scan_addr",  addr_ok,      1);
        repeat (3) @(negedge clk);
        chk("stable_done",  done,         1);
        chk("stable_steps", steps,        e_steps);
        chk("stable_mm",    mismatch_cnt, e_mm);
    endtask

    initial begin
        int k;
        bit ok;
        rst = 1'b0; start = 1'b0; retire = 1'b0; halt = 1'b0;
        fill_equal();
        repeat (2) @(negedge clk);
        chk("rst_hold",  cpu_hold,     1);
        chk("rst_busy",  busy,         0);
        chk("rst_done",  done,         0);
        chk("rst_pass",  pass,         0);
        chk("rst_to",    timeout,      0);
        chk("rst_steps", steps,        0);
        chk("rst_mm",    mismatch_cnt, 0);
        chk("rst_fb",    first_bad,    0);
        chk("rst_raddr", reg_raddr,    0);
        chk("rst_eaddr", exp_addr,     0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        fill_equal();
        build(20, 1, 5, 0);
        run(1'b0);

        fill_equal();
        gpr[7]  = 32'h0000_0005;
        rom[7]  = 32'h0000_0006;
        gpr[12] = rom[12] ^ 32'h0000_0100;
        build(20, 1, 5, 0);
        run(1'b0);

        fill_equal();
        build(200, 4, 4, -1);
        run(1'b0);

        fill_equal();
        build(3, 1, 3, 30);
        run(1'b0);

        fill_equal();
        gpr[31] = ~rom[31];
        build(5, 1, 4, 0);
        run(1'b1);

        for (int r = 0; r < 4; r++) begin
            fill_equal();
            k = $urandom_range(3, 0);
            for (int j = 0; j < k; j++)
                gpr[$urandom_range(NREGS-1, 0)] ^= 32'h1 << $urandom_range(31, 0);
            build($urandom_range(120, 1), 1, 6, $urandom_range(12, 0));
            run(1'b0);
        end

        // Asynchronous reset in the middle of RUN.
        fill_equal();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        ok = 1'b0;
        for (int cyc = 0; cyc < 50 && !ok; cyc++) begin
            if (!cpu_hold) ok = 1'b1;
            else @(negedge clk);
        end
        chk("run_reached", ok, 1);
        retire = 1'b1;
        repeat (3) @(negedge clk);
        retire = 1'b0;
        @(negedge clk);
        chk("pre_rst_steps", steps, 3);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_hold",  cpu_hold,     1);
        chk("mid_rst_busy",  busy,         0);
        chk("mid_rst_steps", steps,        0);
        chk("mid_rst_mm",    mismatch_cnt, 0);
        chk("mid_rst_to",    timeout,      0);
        chk("mid_rst_done",  done,         0);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy,     0);
        chk("post_rst_hold", cpu_hold, 1);

        fill_equal();
        build(8, 1, 3, 1);
        run(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpr_check_seq.md
# gpr_check_seq

Synthesizable run-and-check sequencer for the multicycle MIPS core: holds the CPU in reset, releases it, counts retired instructions until a halt, step limit or watchdog expiry, then scans the general-purpose register file and compares every register against an expected-value ROM. It replaces simulation-only register dumps with a parametrised, cycle-exact checker. It sits beside the `mips` top level, driving the CPU reset and reading a debug read port of `gpr`.

## Interface
- `DATA_W`, 32, register/ROM data width
- `NREGS`, 32, number of registers scanned (indices 0..NREGS-1)
- `AW`, 5, register address width; NREGS <= 2^AW
- `MAX_STEPS`, 100, retire limit before forced stop
- `STEP_TIMEOUT`, 10, cycles allowed between retires before watchdog fires
- `RST_CYCLES`, 2, cycles CPU is held in reset after start

- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle request to begin a run
- `retire` in 1: one-cycle pulse when the CPU control FSM re-enters its fetch state
- `halt` in 1: CPU fetched the end-of-program marker
- `cpu_hold` out 1: drives CPU reset (1 = held)
- `reg_raddr` out AW: GPR debug read address
- `reg_rdata` in DATA_W: GPR data, valid the cycle after `reg_raddr`
- `exp_addr` out AW: expected-ROM address (always equals `reg_raddr`)
- `exp_data` in DATA_W: ROM data, valid the cycle after `exp_addr`
- `busy` out 1: run or scan in progress
- `done` out 1: results valid, held until next start
- `pass` out 1: done, no mismatches, no timeout
- `timeout` out 1: watchdog fired during run
- `steps` out clog2(MAX_STEPS+1): retires counted
- `mismatch_cnt` out clog2(NREGS+1): registers that differed
- `first_bad` out AW: lowest mismatching index (0 when none)

## Operation
- States: IDLE, HOLD, RUN, SCAN, DONE.
- IDLE: `cpu_hold`=1. `start` -> HOLD; clears steps, mismatch_cnt, first_bad, timeout, done, pass.
- HOLD: `cpu_hold`=1 for exactly RST_CYCLES cycles, then RUN.
- RUN: `cpu_hold`=0. Each `retire` increments `steps`. Exit to SCAN when `halt`=1, or `steps` reaches MAX_STEPS, or watchdog fires. Retire and halt in the same cycle: retire counted, then exit.
- Watchdog: counter cleared on entering RUN and on every `retire`; reaching STEP_TIMEOUT sets `timeout`=1 and exits.
- SCAN: `cpu_hold`=1 (freezes register file). Issues addresses 0..NREGS-1 on consecutive cycles; compares `reg_rdata` vs `exp_data` one cycle later. On mismatch: `mismatch_cnt`++; if first mismatch, `first_bad` = index. After last compare -> DONE.
- DONE: `done`=1, `pass` = (mismatch_cnt==0)&~timeout, `busy`=0. `start` -> HOLD (new run). Results stable otherwise.
- `start` in HOLD/RUN/SCAN ignored.
- `rst` low at any time: immediate return to IDLE, all outputs to reset values.

## Timing
- Reset values: `cpu_hold`=1, `busy`=0, `done`=0, `pass`=0, `timeout`=0, `steps`=0, `mismatch_cnt`=0, `first_bad`=0, `reg_raddr`=`exp_addr`=0.
- `busy` high from cycle after `start` until DONE entry.
- HOLD lasts RST_CYCLES; RUN ≥1 cycle; SCAN lasts exactly NREGS+1 cycles.
- `done`/`pass` rise in the same cycle, first DONE cycle.
- All outputs registered; no combinational input-to-output paths.

## Configuration
- `GPRCHK_WATCHDOG_EN`: defined -> watchdog counter and `timeout` as described. Undefined -> no watchdog logic, `timeout` tied 0, RUN exits only on `halt` or MAX_STEPS; STEP_TIMEOUT ignored.

## Test plan
- Reset, start; CPU model retires 20 instructions then asserts halt; ROM equals GPR -> steps=20, mismatch_cnt=0, pass=1, SCAN exactly 33 cycles.
- Same run with GPR[7]=32'h0000_0005, ROM[7]=32'h0000_0006, GPR[12] also wrong -> mismatch_cnt=2, first_bad=7, pass=0.
- Never halt, retire every 4 cycles -> steps=100 at stop, timeout=0, scan runs.
- Watchdog enabled, stop retiring after 3 -> timeout=1 after 10 idle cycles, steps=3, pass=0; with macro undefined run continues until halt.
- Retire and halt same cycle at step 5 -> steps=5; start pulsed during SCAN ignored; rst low mid-RUN -> IDLE, cpu_hold=1, all counters 0.
